// File: rtl/reset_ctrl_pkg.sv
// Shared constants for the reset controller and the RTS status device.
// Holds cause bit positions, FSM state encodings and a helper that builds a cause vector.
package reset_ctrl_pkg;

    localparam int CAUSE_W   = 4;
    localparam int CAUSE_POR = 0;
    localparam int CAUSE_PLL = 1;
    localparam int CAUSE_BTN = 2;
    localparam int CAUSE_WD  = 3;

    localparam logic [1:0] ST_HOLD_ENC    = 2'd0;
    localparam logic [1:0] ST_STRETCH_ENC = 2'd1;
    localparam logic [1:0] ST_RUN_ENC     = 2'd2;

    typedef enum logic [1:0] {
        HOLD    = ST_HOLD_ENC,
        STRETCH = ST_STRETCH_ENC,
        RUN     = ST_RUN_ENC
    } state_t;

    // Software resets have no cause bit, so a sw-only reset reads back as all zeros.
    function automatic logic [CAUSE_W-1:0] cause_bits(input logic pll, input logic btn,
                                                      input logic wd);
        logic [CAUSE_W-1:0] c;
        c            = '0;
        c[CAUSE_PLL] = pll;
        c[CAUSE_BTN] = btn;
        c[CAUSE_WD]  = wd;
        return c;
    endfunction

endpackage

// File: rtl/reset_ctrl_sync_bit.sv
// Two-flop synchronizer for a single asynchronous level.
// INIT is the value both flops take during rst, i.e. the "inactive" level of the input.
module sync_bit #(
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= INIT;
            q    <= INIT;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/reset_ctrl.sv
// System reset controller: conditions PLL lock and button, merges watchdog/software pulses,
// stretches the system reset and records the cause and a saturating count of resets.
module reset_ctrl
    import reset_ctrl_pkg::*;
#(
    parameter int RST_CYCLES      = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_ok,
    input  logic               btn_rst_n,
    input  logic               wd_rst,
    input  logic               sw_rst,
    output logic               rst_out,
    output logic               rst_out_n,
    output logic [CAUSE_W-1:0] cause,
    output logic [CNT_W-1:0]   rst_cnt
);

    localparam int STR_W = $clog2(RST_CYCLES + 1);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

    logic clk_ok_s;
    logic btn_s;
    logic btn_press_s;
    logic btn_db;
    logic [DB_W-1:0] db_cnt;

    sync_bit #(.INIT(1'b0)) u_sync_clk_ok (
        .clk (clk),
        .rst (rst),
        .d   (clk_ok),
        .q   (clk_ok_s)
    );

    sync_bit #(.INIT(1'b1)) u_sync_btn (
        .clk (clk),
        .rst (rst),
        .d   (btn_rst_n),
        .q   (btn_s)
    );

    assign btn_press_s = ~btn_s;

    // Any disagreement with the accepted level that does not persist long enough restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_db <= 1'b0;
            db_cnt <= '0;
        end else if (btn_press_s == btn_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            btn_db <= btn_press_s;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    logic level_src;
    logic pulse_src;
    logic src;

    assign level_src = ~clk_ok_s | btn_db;
    assign pulse_src = wd_rst | sw_rst;
    assign src       = level_src | pulse_src;

    state_t           state;
    state_t           state_d;
    logic [STR_W-1:0] str_cnt;
    logic [STR_W-1:0] str_cnt_d;

    always_comb begin
        state_d   = state;
        str_cnt_d = str_cnt;
        case (state)
            HOLD: begin
                str_cnt_d = '0;
                if (!level_src) state_d = STRETCH;
            end
            STRETCH: begin
                if (level_src) begin
                    state_d   = HOLD;
                    str_cnt_d = '0;
                end else if (pulse_src) begin
                    str_cnt_d = '0;
                end else if (str_cnt == STR_W'(RST_CYCLES - 1)) begin
                    state_d   = RUN;
                    str_cnt_d = '0;
                end else begin
                    str_cnt_d = str_cnt + STR_W'(1);
                end
            end
            RUN: begin
                str_cnt_d = '0;
                if (level_src)      state_d = HOLD;
                else if (pulse_src) state_d = STRETCH;
            end
            default: begin
                state_d   = HOLD;
                str_cnt_d = '0;
            end
        endcase
    end

    // The PLL is expected to be unlocked right after rst, so until the first RUN a missing
    // lock is not reported as a separate cause on top of the power-on bit.
    logic               por_seq;
    logic [CAUSE_W-1:0] src_cause;

    assign src_cause = cause_bits(~clk_ok_s & ~por_seq, btn_db, wd_rst);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HOLD;
            str_cnt   <= '0;
            rst_out   <= 1'b1;
            rst_out_n <= 1'b0;
            cause     <= CAUSE_W'(1) << CAUSE_POR;
            rst_cnt   <= '0;
            por_seq   <= 1'b1;
        end else begin
            state     <= state_d;
            str_cnt   <= str_cnt_d;
            rst_out   <= (state_d != RUN);
            rst_out_n <= (state_d == RUN);
            if (state == RUN) begin
                por_seq <= 1'b0;
                if (src) begin
                    cause <= src_cause;
                    if (rst_cnt != '1) rst_cnt <= rst_cnt + CNT_W'(1);
                end
            end else begin
                cause <= cause | src_cause;
            end
        end
    end

endmodule
